// File: rtl/rt_param_if.sv
// rt_param_if: operand/result handshake bundle for rt_param
interface rt_param_if #(parameter int WIDTH = 8);
  localparam int RW = (WIDTH + 1) / 2;
  logic [WIDTH-1:0] a_i;
  logic mode_i;
  logic start_i;
  logic [RW-1:0] y_bo;
  logic [WIDTH-1:0] r_bo;
  logic busy_o;
  logic done_o;
  modport master(output a_i, mode_i, start_i, input y_bo, r_bo, busy_o, done_o);
  modport slave(input a_i, mode_i, start_i, output y_bo, r_bo, busy_o, done_o);
endinterface

// File: rtl/rt_param.sv
// rt_param: sequential digit-by-digit cube/square root with remainder
module rt_param #(
  parameter int WIDTH = 8,
  parameter int SERIAL_MUL = 1
) (
  input logic clk_i,
  input logic rst_i,
  rt_param_if.slave bus
);
  localparam int RW = (WIDTH + 1) / 2;
  localparam int CI = (WIDTH + 2) / 3;
  localparam int SI = (WIDTH + 1) / 2;
  localparam int M = SERIAL_MUL ? RW : 1;
  localparam int PW = WIDTH + 3;
  localparam int BW = PW + WIDTH;
  localparam int KW = $clog2(RW + 1);
  localparam int CW = $clog2(M + 1);
  typedef enum logic [2:0] {IDLE, STEP, MUL, TEST, DONE} state_t;
  state_t state, state_n;
  logic mode, busy, start_ok, take, last;
  logic [RW-1:0] y_int, y_n;
  logic [WIDTH-1:0] x, x_n;
  logic [KW-1:0] k;
  logic [KW+1:0] s;
  logic [CW-1:0] cnt;
  logic [PW-1:0] acc, mc, mr, prod, addend, p;
  logic [BW-1:0] b;
  assign busy = state inside {STEP, MUL, TEST};
  assign start_ok = bus.start_i && !busy;
  assign bus.busy_o = busy;
  assign bus.done_o = state == DONE;
  // p = 3*y*(y+1) + 1, either in one shot or one partial product per MUL cycle
  assign mc = PW'(y_int) * PW'(3);
  assign mr = PW'(y_int) + PW'(1);
  assign prod = mc * mr + PW'(1);
  assign addend = mr[cnt] ? mc << cnt : '0;
  assign p = mode ? {PW'(y_int), 1'b0} | PW'(1) : acc;
  assign s = mode ? {k, 1'b0} : {k, 1'b0} + (KW+2)'(k);
  assign b = BW'(p) << s;
  assign take = BW'(x) >= b;
  assign x_n = take ? x - WIDTH'(b) : x;
  assign y_n = y_int + RW'(take);
  assign last = k == '0;
  always_ff @(posedge clk_i)
    state <= rst_i ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: state_n = start_ok ? STEP : IDLE;
      STEP: state_n = mode ? TEST : MUL;
      MUL: state_n = cnt == CW'(M - 1) ? TEST : MUL;
      TEST: state_n = last ? DONE : STEP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (start_ok) begin
      mode <= bus.mode_i;
      x <= bus.a_i;
      y_int <= '0;
      k <= bus.mode_i ? KW'(SI - 1) : KW'(CI - 1);
    end
    if (state == STEP) begin
      y_int <= y_int << 1;
      cnt <= '0;
      acc <= PW'(1);
    end
    if (state == MUL) begin
      acc <= SERIAL_MUL != 0 ? acc + addend : prod;
      cnt <= cnt + 1'b1;
    end
    if (state == TEST) begin
      x <= x_n;
      y_int <= y_n;
      k <= k - 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.y_bo <= '0;
      bus.r_bo <= '0;
    end else if (state == TEST && last) begin
      bus.y_bo <= y_n;
      bus.r_bo <= x_n;
    end
  end
endmodule

// File: tb/tb_rt_param.sv
// tb_rt_param: randomized and directed checks of rt_param against an integer-root model
module tb_rt_param;
  logic clk = 0, rst = 1;
  logic [7:0] a8 = '0;
  logic m8 = 0, s8 = 0;
  logic [15:0] a16 = '0;
  logic m16 = 0, s16 = 0;
  int ntot = 0, npass = 0;
  rt_param_if #(.WIDTH(8)) i8s();
  rt_param_if #(.WIDTH(8)) i8c();
  rt_param_if #(.WIDTH(16)) i16();
  assign i8s.a_i = a8;
  assign i8s.mode_i = m8;
  assign i8s.start_i = s8;
  assign i8c.a_i = a8;
  assign i8c.mode_i = m8;
  assign i8c.start_i = s8;
  assign i16.a_i = a16;
  assign i16.mode_i = m16;
  assign i16.start_i = s16;
  rt_param #(.WIDTH(8), .SERIAL_MUL(1)) u8s (.clk_i(clk), .rst_i(rst), .bus(i8s));
  rt_param #(.WIDTH(8), .SERIAL_MUL(0)) u8c (.clk_i(clk), .rst_i(rst), .bus(i8c));
  rt_param #(.WIDTH(16), .SERIAL_MUL(1)) u16 (.clk_i(clk), .rst_i(rst), .bus(i16));
  always #5 clk = ~clk;
  task automatic check(input string tag, input longint got, input longint exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  function automatic longint pw(input longint v, input bit sq);
    return sq ? v * v : v * v * v;
  endfunction
  function automatic longint iroot(input longint a, input bit sq);
    longint y = 0;
    while (pw(y + 1, sq) <= a) y++;
    return y;
  endfunction
  function automatic int lat(input int w, input int rw, input bit sq);
    return sq ? ((w + 1) / 2) * 2 : ((w + 2) / 3) * (rw + 2);
  endfunction
  task automatic wait8(input int hold, input bit scr, output int bs, output int bc, output int ds, output int dc);
    bs = 0; bc = 0; ds = 0; dc = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      bs += int'(i8s.busy_o); bc += int'(i8c.busy_o);
      ds += int'(i8s.done_o); dc += int'(i8c.done_o);
      if (c == hold - 1) s8 = 0;
      if (scr && c >= hold) begin
        a8 = 8'($urandom);
        m8 = 1'($urandom);
      end
    end
  endtask
  task automatic res8(input longint a, input bit sq, input int bs, input int bc, input int ds, input int dc);
    longint ey = iroot(a, sq);
    check("y8_serial", i8s.y_bo, ey);
    check("r8_serial", i8s.r_bo, a - pw(ey, sq));
    check("y8_comb", i8c.y_bo, ey);
    check("r8_comb", i8c.r_bo, a - pw(ey, sq));
    check("busy8_serial", bs, lat(8, 4, sq));
    check("busy8_comb", bc, lat(8, 1, sq));
    check("done8_serial", ds, 1);
    check("done8_comb", dc, 1);
  endtask
  task automatic op8(input int a, input bit sq, input int hold, input bit scr);
    int bs, bc, ds, dc;
    @(negedge clk); a8 = 8'(a); m8 = sq; s8 = 1;
    wait8(hold, scr, bs, bc, ds, dc);
    res8(a, sq, bs, bc, ds, dc);
  endtask
  task automatic op16(input int a, input bit sq);
    int bs = 0;
    bit got = 0;
    longint ey = iroot(a, sq);
    @(negedge clk); a16 = 16'(a); m16 = sq; s16 = 1;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (c == 0) s16 = 0;
      bs += int'(i16.busy_o);
      got = i16.done_o;
    end
    check("done16", got, 1);
    check("y16", i16.y_bo, ey);
    check("r16", i16.r_bo, a - pw(ey, sq));
    check("busy16", bs, lat(16, 8, sq));
  endtask
  initial begin
    int bs, bc, ds, dc;
    bit found;
    repeat (3) @(negedge clk);
    check("rst_y", i8s.y_bo, 0);
    check("rst_r", i8s.r_bo, 0);
    check("rst_busy", i8s.busy_o, 0);
    check("rst_done", i8c.done_o, 0);
    rst = 0;
    op8(63, 0, 2, 0);
    op8(255, 0, 1, 0);
    op8(64, 0, 1, 0);
    op8(0, 0, 1, 0);
    op8(200, 1, 1, 0);
    op8(0, 1, 1, 0);
    op8(125, 0, 1, 1);
    op8(144, 1, 1, 1);
    // square then a cube started in the DONE cycle
    @(negedge clk); a8 = 8'd255; m8 = 1; s8 = 1;
    @(negedge clk); s8 = 0;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      found = i8s.done_o;
    end
    check("b2b_done", found, 1);
    check("b2b_y_sq", i8s.y_bo, 15);
    check("b2b_r_sq", i8c.r_bo, 30);
    a8 = 8'd27; m8 = 0; s8 = 1;
    wait8(1, 0, bs, bc, ds, dc);
    res8(27, 0, bs, bc, ds, dc);
    // reset mid-operation
    @(negedge clk); a8 = 8'd200; m8 = 0; s8 = 1;
    @(negedge clk); s8 = 0;
    repeat (4) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("abort_busy", i8s.busy_o, 0);
    check("abort_y", i8s.y_bo, 0);
    check("abort_r", i8c.r_bo, 0);
    check("abort_busy_comb", i8c.busy_o, 0);
    rst = 0;
    ds = 0;
    repeat (25) begin
      @(negedge clk);
      ds += int'(i8s.done_o) + int'(i8c.done_o);
    end
    check("abort_no_done", ds, 0);
    op8(200, 0, 1, 0);
    for (int i = 0; i < 40; i++) op8(int'($urandom_range(0, 255)), 1'($urandom), 1, 0);
    op16(0, 0);
    op16(0, 1);
    op16(65535, 0);
    op16(65535, 1);
    op16(32768, 0);
    op16(4096, 0);
    op16(65025, 1);
    for (int i = 0; i < 150; i++) op16(int'($urandom_range(0, 65535)), 1'($urandom));
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
